// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_lite_sram_mem.sv
// Word-organised SRAM array with per-byte write enables and asynchronous read.
module ahb_lite_sram_mem #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int i = 0; i < DATA_W/8; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end

  // Async read lets a read right after a write to the same word see new data.
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ahb_lite_sram.sv
// AHB-Lite SRAM slave with pipelined address/data phases and WAIT_STATES stall cycles.
// Define AHB_LITE_SRAM_ERR_EN for ERROR responses on out-of-range, oversize or unaligned accesses.
module ahb_lite_sram
  import ahb_lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 8,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int NB = HDATA_SIZE / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LB);

  state_t                state_q;
  logic [HADDR_SIZE-1:0] addr_q;
  logic [2:0]            size_q, size_d;
  logic                  write_q, dphase_q, hready_q, hresp_q;
  logic [3:0]            cnt_q;
  logic [HDATA_SIZE-1:0] rdata_q, mem_rdata;
  logic [NB-1:0]         be;
  logic [LB-1:0]         off;
  logic [31:0]           word_full;
  logic [AW-1:0]         widx;
  logic                  sample, err, last, we;
  logic                  unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

  assign sample = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
                  && (state_q == ST_IDLE || state_q == ST_ERR2);
  assign size_d = (HSIZE > MAX_SIZE) ? MAX_SIZE : HSIZE;

`ifdef AHB_LITE_SRAM_ERR_EN
  assign err = (32'(HADDR >> LB) >= 32'(MEM_DEPTH)) || (HSIZE > MAX_SIZE)
               || ((HADDR[2:0] & ((3'b1 << HSIZE) - 3'b1)) != 3'b0);
`else
  assign err = 1'b0;
`endif

  assign last      = dphase_q && hready_q;
  assign we        = last && write_q && !HRESET;
  assign word_full = 32'(addr_q >> LB);
  assign widx      = AW'(word_full % 32'(MEM_DEPTH));
  assign off       = addr_q[LB-1:0];

  // A lane is enabled when it shares the size-aligned block with the address.
  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++)
      be[i] = ((LB'(i) ^ off) >> size_q) == '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      dphase_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (last && !write_q) rdata_q <= mem_rdata;
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          dphase_q <= 1'b0;
          if (sample) begin
            addr_q  <= HADDR;
            size_q  <= size_d;
            write_q <= HWRITE;
            if (err) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else begin
              dphase_q <= 1'b1;
              if (WAIT_STATES > 0) begin
                state_q  <= ST_WAIT;
                hready_q <= 1'b0;
                cnt_q    <= 4'(WAIT_STATES - 1);
              end
            end
          end
        end
      endcase
    end
  end

  ahb_lite_sram_mem #(
    .DATA_W(HDATA_SIZE), .DEPTH(MEM_DEPTH), .AW(AW), .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk_i(HCLK), .we_i(we), .be_i(be), .addr_i(widx), .wdata_i(HWDATA), .rdata_o(mem_rdata)
  );

  assign HRDATA    = (last && !write_q) ? mem_rdata : rdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
endmodule
